booth_radix4_mul: RTL and testbench

//   Parametrised sequential radix-4 (modified) Booth multiplier, next generation of the radix-2 unit.

---
 rtl/booth_radix4_mul.sv | 112 +++++++++++
 tb/tb_booth_radix4_mul.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per cycle, signed/unsigned per operation.
// Optional build macro BOOTH_MUL_ZERO_SKIP_EN: zero operands bypass the iteration loop.
module booth_radix4_mul #(
    parameter int W = 16
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           In_Valid,
    output logic           In_Ready,
    input  logic           Signed,
    input  logic [W-1:0]   M,
    input  logic [W-1:0]   Q,
    output logic           Out_Valid,
    input  logic           Out_Ready,
    output logic [2*W-1:0] P
);
    localparam int N  = (W + 2) / 2;
    localparam int CW = $clog2(N + 1);
    localparam int XW = W + 2;
    localparam int AW = W + 3;
    localparam int SW = W + 4;

    // Handshakes: a transfer happens on a rising Clock edge where valid and ready are both 1;
    // In_Ready is high only in IDLE, Out_Valid only in DONE, and neither depends on the peer's signal.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [XW:0]   mult_q, mult_d;
    logic [XW-1:0] qx_q, qx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [XW-1:0] mx_in, qx_in;
    logic [SW-1:0] qe, addend, sum;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mult_q  <= '0;
            qx_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mult_q  <= mult_d;
            qx_q    <= qx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mult_d  = mult_q;
        qx_d    = qx_q;
        cnt_d   = cnt_q;

        mx_in = Signed ? {{2{M[W-1]}}, M} : {2'b00, M};
        qx_in = Signed ? {{2{Q[W-1]}}, Q} : {2'b00, Q};

        qe = {{2{qx_q[XW-1]}}, qx_q};
        case (mult_q[2:0])
            3'b001, 3'b010: addend = qe;
            3'b011:         addend = qe << 1;
            3'b100:         addend = -(qe << 1);
            3'b101, 3'b110: addend = -qe;
            default:        addend = '0;
        endcase
        // One guard bit above the accumulator so the add can never wrap before the shift.
        sum = {acc_q[AW-1], acc_q} + addend;

        case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    qx_d    = qx_in;
                    acc_d   = '0;
                    mult_d  = {mx_in, 1'b0};
                    cnt_d   = CW'(N);
                    state_d = RUN;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
                    if (M == '0 || Q == '0) begin
                        mult_d  = '0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_d  = {sum[SW-1], sum[SW-1:2]};
                mult_d = {sum[1:0], mult_q[XW:2]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Out_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign In_Ready  = (state_q == IDLE);
    assign Out_Valid = (state_q == DONE);
    // acc/mult freeze in DONE, so the product is taken straight from them; bit 0 of mult is spent recode history.
    assign P = (state_q == DONE) ? {acc_q[W-3:0], mult_q[XW:1]} : '0;

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul (W=16): directed corner cases plus randomized ops with backpressure.
module tb_booth_radix4_mul;
    localparam int W = 16;
    localparam int N = (W + 2) / 2;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           In_Valid;
    logic           In_Ready;
    logic           Signed;
    logic [W-1:0]   M;
    logic [W-1:0]   Q;
    logic           Out_Valid;
    logic           Out_Ready;
    logic [2*W-1:0] P;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    booth_radix4_mul #(.W(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Signed    (Signed),
        .M         (M),
        .Q         (Q),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .P         (P)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the operands, truncated to 2W bits.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
        longint a, b, p;
        if (s) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        p = a * b;
        return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = 16'h8000;
            2:       v = 16'h7FFF;
            3:       v = 16'hFFFF;
            4:       v = 16'h0001;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // driver tasks
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
        @(negedge Clock);
        In_Valid = 1'b1;
        M        = m;
        Q        = q;
        Signed   = s;
        check("in_ready_idle", 64'(In_Ready), 64'd1);
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        M        = W'($urandom);
        Q        = W'($urandom);
        Signed   = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s,
                          input int hold, input logic [2*W-1:0] expected);
        int lat;
        int exp_lat;
        logic [2*W-1:0] exp_p;
        exp_q.push_back(expected);
        exp_lat = N;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
        if (m == '0 || q == '0) exp_lat = 0;
`endif
        start_op(m, q, s);
        lat = 0;
        while (!Out_Valid && lat < 100) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        exp_p = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(Out_Valid), 64'd1);
            check("hold_p", 64'(P), 64'(exp_p));
            check("hold_in_ready", 64'(In_Ready), 64'd0);
            In_Valid = 1'b1;
            M        = W'($urandom);
            Q        = W'($urandom);
            Signed   = 1'($urandom);
            @(posedge Clock);
            #1;
        end
        check("out_valid", 64'(Out_Valid), 64'd1);
        check("product", 64'(P), 64'(exp_p));
        Out_Ready = 1'b1;
        @(posedge Clock);
        #1;
        Out_Ready = 1'b0;
        In_Valid  = 1'b0;
        check("post_valid", 64'(Out_Valid), 64'd0);
        check("post_p", 64'(P), 64'd0);
        check("post_in_ready", 64'(In_Ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] rm, rq;
        logic         rs;

        Reset     = 1'b0;
        In_Valid  = 1'b0;
        M         = '0;
        Q         = '0;
        Signed    = 1'b0;
        Out_Ready = 1'b0;
        #12;
        check("reset_out_valid", 64'(Out_Valid), 64'd0);
        check("reset_p", 64'(P), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_in_ready", 64'(In_Ready), 64'd1);

        run_op(16'hFFFD, 16'h0005, 1'b1, 0, 32'hFFFF_FFF1);
        run_op(16'h8000, 16'h8000, 1'b1, 0, 32'h4000_0000);
        run_op(16'h7FFF, 16'h8000, 1'b1, 1, 32'hC000_8000);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE_0001);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 32'h0000_0001);
        // backpressure with new operands presented while DONE, then the next op straight after
        run_op(16'h0123, 16'h0456, 1'b0, 5, 32'h0004_EDC2);
        run_op(16'hFFFE, 16'h0003, 1'b1, 0, 32'hFFFF_FFFA);

        // reset in the middle of RUN discards the operation
        start_op(16'h1234, 16'h5678, 1'b1);
        repeat (3) @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(Out_Valid), 64'd0);
        check("abort_p", 64'(P), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_in_ready", 64'(In_Ready), 64'd1);
        run_op(16'h0007, 16'hFFFE, 1'b1, 0, 32'hFFFF_FFF2);

        run_op(16'h0000, 16'd1234, 1'b0, 1, 32'h0000_0000);
        run_op(16'd1234, 16'h0000, 1'b1, 0, 32'h0000_0000);

        for (int i = 0; i < 1500; i++) begin
            rm = pick_operand();
            rq = pick_operand();
            rs = 1'($urandom);
            run_op(rm, rq, rs, $urandom_range(0, 3), model(rm, rq, rs));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
